obb_rotate_seq: RTL and testbench
=================================

# obb_rotate_seq

Sequencer for the `rotate` stage of the OBB pipeline. It replaces hand-driven `state` codes with an FSM that steps `rotate` through its six computation phases and checks each phase against the `ctrl_rotate` echo. It also guards every phase with a timeout. On completion it captures the 3×3 rotation matrix into a result bank and pulses `done` to the collision stage.

## Interface
Parameters:
- `DW`, 21: width of each matrix element; matches `rotate` outputs.
- `TIMEOUT`, 15: maximum cycles to wait for the echo after a phase code is issued; legal range 2..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to run a rotation; sampled only in IDLE.
- `abort`  in  1  synchronous abort; sampled in every state.
- `state_o`  out  4  phase code driven to `rotate.state`; registered.
- `ctrl_rotate`  in  3  echo from `rotate`.
- `o_in`  in  9*DW  `rotate` o1..o9, with o1 at the LSBs.
- `r_out`  out  9*DW  captured matrix; holds its value until the next successful run.
- `busy`  out  1  high from the cycle after `start` is accepted until the run finishes.
- `done`  out  1  one-cycle pulse; `r_out` is valid in the same cycle.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- Phase codes:
  - IDLE = 4'b1001
  - CLR0 = 4'b0001
  - CLR1 = 4'b0010
  - P1..P6 = 4'b0011, 0100, 0101, 0110, 0111, 1000
  - Expected echoes: 0 for CLR0/CLR1, and 1..6 for P1..P6.
- FSM states:
  - IDLE: `state_o` = IDLE code.
  - CLR0 and CLR1: one cycle each; no echo check.
  - ISSUE_k then WAIT_k, for k = 1..6.
  - CAPTURE.
- Transitions:
  - IDLE → CLR0 on `start` && !`abort`.
  - CLR0 → CLR1 → ISSUE_1.
  - ISSUE_k drives P_k for one cycle, then goes to WAIT_k. `state_o` continues to hold P_k during WAIT_k.
  - WAIT_k → ISSUE_k+1 when `ctrl_rotate` == k.
  - WAIT_6 → CAPTURE when `ctrl_rotate` == 6.
  - CAPTURE: `r_out` ← `o_in`, `done` = 1, → IDLE.
- Timeout:
  - An 8-bit step timer clears on every ISSUE and increments each WAIT cycle in which the echo mismatches.
  - When the timer reaches TIMEOUT while the echo still mismatches: `err` pulses next cycle, the FSM goes to IDLE, and `r_out` is unchanged.
- Abort: in any non-IDLE state, `abort` forces IDLE next cycle, with no `done` and no `err`. `abort` has priority over echo match, timeout and CAPTURE.
- `start` while `busy` is ignored. It is not queued.
- `done` and `err` are never high in the same cycle.
- Reset values: `state_o` = 4'b1001; `busy`, `done`, `err` = 0; `r_out` = 0; step timer = 0; FSM = IDLE.
- Reset mid-run returns to IDLE next cycle with the values above. `rotate` is left unchanged until the next CLR0.

## Timing
- `start` sampled at edge 0 → `state_o`:
  - CLR0 in cycle 1, CLR1 in cycle 2
  - P1 in cycle 3, P2 in 5, P3 in 7, P4 in 9, P5 in 11, P6 in 13
- Echo 6 is seen in cycle 14. `done` and the new `r_out` appear in cycle 15, and `busy` drops in cycle 15.
- Nominal latency from `start` to `done` is 15 cycles. Each echo delay of d extra cycles adds d.
- `busy` is high in cycles 1..14.
- A new `start` is accepted from cycle 15 onward.
- Stale echo: during ISSUE_k the previous echo (k-1) is still present. Only WAIT_k compares, and only against k.

## Structure
- Shared package `obb_pkg`:
  - phase-code localparams (`ST_IDLE`, `ST_CLR0`, `ST_CLR1`, `ST_P1`..`ST_P6`)
  - expected-echo constants
  - `DW`
  - FSM state enum, which `rotate` testbenches also use.
- One sub-module, `obb_step_timer`, with ports `clr`, `en` and `expired`, parameterised by TIMEOUT.
- FSM, capture register and pulse logic live in the top module.

## Test plan
- Nominal run with a behavioural `rotate` that echoes in 1 cycle and sets `o_in` = {100,0,0,0,97,-24,0,24,97} → `state_o` sequence exactly as in Timing. `done` in cycle 15 and `r_out` equals `o_in`; `busy` is high in cycles 1..14.
- Echo stuck at 3 in WAIT_4, TIMEOUT=15 → `err` pulses once 16 cycles after P4 is issued. `state_o` returns to 4'b1001, `done` stays 0, and `r_out` keeps its previous value.
- `abort` in cycle 8 → IDLE in cycle 9 with `state_o` = 4'b1001 and no `done`/`err`. A `start` in cycle 10 completes normally 15 cycles later.
- `start` pulsed in cycles 0 and 6 → exactly one run and one `done`, in cycle 15. `start` together with `abort` in IDLE → no run.
- `rst` asserted in cycle 10 → all outputs at reset values from cycle 11, including `r_out` = 0.
- Echo delayed 3 extra cycles in WAIT_2 only → `done` in cycle 18. No `err`, because 3 < TIMEOUT.

Source files
------------

// File: rtl/obb_pkg.sv
// Shared definitions for the OBB rotate stage: phase codes, expected echoes,
// element width and the sequencer state encoding.
package obb_pkg;

    localparam int DW = 21;

    localparam logic [3:0] ST_IDLE = 4'b1001;
    localparam logic [3:0] ST_CLR0 = 4'b0001;
    localparam logic [3:0] ST_CLR1 = 4'b0010;
    localparam logic [3:0] ST_P1   = 4'b0011;
    localparam logic [3:0] ST_P2   = 4'b0100;
    localparam logic [3:0] ST_P3   = 4'b0101;
    localparam logic [3:0] ST_P4   = 4'b0110;
    localparam logic [3:0] ST_P5   = 4'b0111;
    localparam logic [3:0] ST_P6   = 4'b1000;

    localparam logic [2:0] ECHO_CLR = 3'd0;
    localparam logic [2:0] ECHO_P1  = 3'd1;
    localparam logic [2:0] ECHO_P2  = 3'd2;
    localparam logic [2:0] ECHO_P3  = 3'd3;
    localparam logic [2:0] ECHO_P4  = 3'd4;
    localparam logic [2:0] ECHO_P5  = 3'd5;
    localparam logic [2:0] ECHO_P6  = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR0,
        S_CLR1,
        S_ISSUE1, S_WAIT1,
        S_ISSUE2, S_WAIT2,
        S_ISSUE3, S_WAIT3,
        S_ISSUE4, S_WAIT4,
        S_ISSUE5, S_WAIT5,
        S_ISSUE6, S_WAIT6,
        S_CAPTURE
    } rot_state_t;

    // Code presented to rotate.state while the sequencer sits in state s.
    function automatic logic [3:0] phase_code(input rot_state_t s);
        case (s)
            S_CLR0:             return ST_CLR0;
            S_CLR1:             return ST_CLR1;
            S_ISSUE1, S_WAIT1:  return ST_P1;
            S_ISSUE2, S_WAIT2:  return ST_P2;
            S_ISSUE3, S_WAIT3:  return ST_P3;
            S_ISSUE4, S_WAIT4:  return ST_P4;
            S_ISSUE5, S_WAIT5:  return ST_P5;
            S_ISSUE6, S_WAIT6:  return ST_P6;
            default:            return ST_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] wait_echo(input rot_state_t s);
        case (s)
            S_WAIT1: return ECHO_P1;
            S_WAIT2: return ECHO_P2;
            S_WAIT3: return ECHO_P3;
            S_WAIT4: return ECHO_P4;
            S_WAIT5: return ECHO_P5;
            S_WAIT6: return ECHO_P6;
            default: return ECHO_CLR;
        endcase
    endfunction

    function automatic logic is_wait(input rot_state_t s);
        return s inside {S_WAIT1, S_WAIT2, S_WAIT3, S_WAIT4, S_WAIT5, S_WAIT6};
    endfunction

    function automatic logic is_issue(input rot_state_t s);
        return s inside {S_ISSUE1, S_ISSUE2, S_ISSUE3, S_ISSUE4, S_ISSUE5, S_ISSUE6};
    endfunction

    // Successor along the nominal path (echo matched, no abort, no timeout).
    function automatic rot_state_t advance(input rot_state_t s);
        case (s)
            S_CLR0:   return S_CLR1;
            S_CLR1:   return S_ISSUE1;
            S_ISSUE1: return S_WAIT1;
            S_WAIT1:  return S_ISSUE2;
            S_ISSUE2: return S_WAIT2;
            S_WAIT2:  return S_ISSUE3;
            S_ISSUE3: return S_WAIT3;
            S_WAIT3:  return S_ISSUE4;
            S_ISSUE4: return S_WAIT4;
            S_WAIT4:  return S_ISSUE5;
            S_ISSUE5: return S_WAIT5;
            S_WAIT5:  return S_ISSUE6;
            S_ISSUE6: return S_WAIT6;
            S_WAIT6:  return S_CAPTURE;
            default:  return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/obb_step_timer.sv
// Per-phase echo timer: cleared when a phase is issued, counts mismatching wait
// cycles, and flags the mismatching cycle that brings the count to TIMEOUT.
module obb_step_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // TIMEOUT mismatching cycles are tolerated; the last one raises expired.
    assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/obb_rotate_seq.sv
// Sequencer stepping the rotate stage through CLR0/CLR1 and phases P1..P6,
// checking each echo under a timeout and capturing the rotation matrix.
module obb_rotate_seq #(
    parameter int DW      = 21,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [3:0]      state_o,
    input  logic [2:0]      ctrl_rotate,
    input  logic [9*DW-1:0] o_in,
    output logic [9*DW-1:0] r_out,
    output logic            busy,
    output logic            done,
    output logic            err
);

    import obb_pkg::*;

    rot_state_t state;
    rot_state_t nxt;
    logic       wait_st;
    logic       issue_st;
    logic       match;
    logic       timer_en;
    logic       expired;
    logic       capture;
    logic       timeout;

    obb_step_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (issue_st),
        .en     (timer_en),
        .expired(expired)
    );

    // Only WAIT_k compares, so the stale echo k-1 seen during ISSUE_k is harmless.
    always_comb begin
        wait_st  = is_wait(state);
        issue_st = is_issue(state);
        match    = (ctrl_rotate == wait_echo(state));
        timer_en = wait_st && !match;
        capture  = !abort && (state == S_WAIT6) && match;
        timeout  = !abort && timer_en && expired;
        nxt      = advance(state);
        if (abort && state != S_IDLE) begin
            nxt = S_IDLE;
        end else if (state == S_IDLE || state == S_CAPTURE) begin
            nxt = (start && !abort) ? S_CLR0 : S_IDLE;
        end else if (timer_en) begin
            nxt = expired ? S_IDLE : state;
        end
    end

    // CAPTURE already presents the idle code and accepts a new start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            state_o <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            r_out   <= '0;
        end else begin
            state   <= nxt;
            state_o <= phase_code(nxt);
            busy    <= !(nxt inside {S_IDLE, S_CAPTURE});
            done    <= capture;
            err     <= timeout;
            if (capture) begin
                r_out <= o_in;
            end
        end
    end

endmodule

// File: tb/tb_obb_rotate_seq.sv
// Directed bench for obb_rotate_seq with a behavioural rotate echo model and a
// done/err scoreboard keyed on the expected cycle of each pulse.
module tb_obb_rotate_seq;

    import obb_pkg::*;

    localparam int W  = 21;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [3:0]     state_o;
    logic [2:0]     ctrl_rotate = 3'd0;
    logic [9*W-1:0] o_in = '0;
    logic [9*W-1:0] r_out;
    logic           busy;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    obb_rotate_seq #(
        .DW     (W),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .state_o    (state_o),
        .ctrl_rotate(ctrl_rotate),
        .o_in       (o_in),
        .r_out      (r_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural rotate: echoes one cycle after seeing a code, optionally
    // holding back a given phase for extra cycles or never answering it.
    int extra_phase = 0;
    int extra_n     = 0;
    int stuck_phase = 0;

    always @(posedge clk) begin : rot_model
        logic [3:0] prev_code;
        int         seen;
        int         k;
        if (state_o == prev_code) seen = seen + 1;
        else seen = 1;
        prev_code = state_o;
        k = 0;
        if (state_o >= ST_P1 && state_o <= ST_P6) k = int'(state_o) - 2;
        if (state_o == ST_CLR0 || state_o == ST_CLR1) begin
            ctrl_rotate <= 3'd0;
        end else if (k >= 1 && k != stuck_phase &&
                     seen >= 1 + ((k == extra_phase) ? extra_n : 0)) begin
            ctrl_rotate <= 3'(k);
        end
    end

    typedef struct {
        int             when;
        bit             is_err;
        logic [9*W-1:0] r;
    } ev_t;

    ev_t sb[$];

    always @(posedge clk) begin : mon
        ev_t ev;
        #1;
        if (done || err) begin
            check("pulse_exclusive", {done, err} == 2'b11, 1'b0);
            check("pulse_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                ev = sb.pop_front();
                check("pulse_cycle", cyc, ev.when);
                check("pulse_err", err, ev.is_err);
                check("pulse_done", done, !ev.is_err);
                check("pulse_rout", r_out, ev.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge; afterwards the bench sits in cycle 1 and cycle c
    // of the run is observed when cyc == s + c - 1.
    task automatic launch(output int s);
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [3:0] exp_code(input int c);
        if (c == 1) return ST_CLR0;
        if (c == 2) return ST_CLR1;
        if (c >= 3 && c <= 14) return 4'(2 + (c - 1) / 2);
        return ST_IDLE;
    endfunction

    logic [9*W-1:0] mat0;
    logic [9*W-1:0] mat1;
    int m0[9] = '{100, 0, 0, 0, 97, -24, 0, 24, 97};
    int m1[9] = '{0, -100, 0, 100, 0, 0, 0, 0, 100};

    initial begin
        int s;
        for (int i = 0; i < 9; i++) begin
            mat0[i*W +: W] = W'(m0[i]);
            mat1[i*W +: W] = W'(m1[i]);
        end
        o_in = mat0;

        // Reset state
        tick();
        tick();
        check("rst_state_o", state_o, ST_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rout", r_out, '0);
        rst = 1'b0;
        tick();

        // Nominal run
        launch(s);
        sb.push_back('{s + 14, 1'b0, mat0});
        for (int c = 1; c <= 16; c++) begin
            check("nom_state_o", state_o, exp_code(c));
            check("nom_busy", busy, c <= 14);
            if (c == 15) check("nom_rout", r_out, mat0);
            tick();
        end

        // Echo stuck at 3 during WAIT_4: timeout, r_out keeps mat0
        o_in = mat1;
        stuck_phase = 4;
        launch(s);
        sb.push_back('{s + 24, 1'b1, mat0});
        for (int c = 1; c <= 27; c++) begin
            if (c == 24) begin
                check("to_state_wait", state_o, ST_P4);
                check("to_busy_wait", busy, 1'b1);
            end
            if (c == 25) begin
                check("to_state_idle", state_o, ST_IDLE);
                check("to_busy_idle", busy, 1'b0);
                check("to_rout_kept", r_out, mat0);
            end
            tick();
        end
        stuck_phase = 0;

        // Abort in cycle 8, restart in cycle 10
        launch(s);
        for (int c = 1; c <= 7; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state_o", state_o, ST_IDLE);
        check("abort_busy", busy, 1'b0);
        tick();
        launch(s);
        sb.push_back('{s + 14, 1'b0, mat1});
        for (int c = 1; c <= 16; c++) begin
            if (c == 14) check("restart_busy", busy, 1'b1);
            if (c == 15) check("restart_rout", r_out, mat1);
            tick();
        end

        // Second start while busy is ignored
        o_in = mat0;
        launch(s);
        sb.push_back('{s + 14, 1'b0, mat0});
        for (int c = 1; c <= 16; c++) begin
            start = (c == 6);
            if (c == 7) check("busy_start_state_o", state_o, ST_P3);
            tick();
        end
        start = 1'b0;

        // start together with abort in IDLE starts nothing
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_state_o", state_o, ST_IDLE);
        check("sa_busy", busy, 1'b0);
        tick();
        check("sa_state_o_later", state_o, ST_IDLE);

        // Reset in cycle 10 of a run
        o_in = mat1;
        launch(s);
        for (int c = 1; c <= 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state_o", state_o, ST_IDLE);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_rout", r_out, '0);
        for (int c = 1; c <= 5; c++) tick();

        // Echo for P2 delayed by 3 cycles: done in cycle 18
        extra_phase = 2;
        extra_n = 3;
        launch(s);
        sb.push_back('{s + 17, 1'b0, mat1});
        for (int c = 1; c <= 19; c++) begin
            if (c == 9) check("dly_state_p2", state_o, ST_P2);
            if (c == 10) check("dly_state_p3", state_o, ST_P3);
            if (c == 18) begin
                check("dly_rout", r_out, mat1);
                check("dly_busy", busy, 1'b0);
            end
            tick();
        end
        extra_phase = 0;
        extra_n = 0;

        tick();
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
